// File: rtl/shape_edge_sequencer.sv
// Fetches one shape's vertices from RAM and issues its edges to a line drawer one at a time.
// Optional macro SHAPE_OFFSET_EN adds latched offset_x/offset_y to every emitted coordinate.
module shape_edge_sequencer #(
    parameter int COORD_W   = 10,
    parameter int NUM_VERTS = 4,
    parameter int SHAPE_W   = 3,
    localparam int ADDR_W   = SHAPE_W + $clog2(2*NUM_VERTS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SHAPE_W-1:0] shape_sel,
    input  logic               closed,
`ifdef SHAPE_OFFSET_EN
    input  logic [COORD_W-1:0] offset_x,
    input  logic [COORD_W-1:0] offset_y,
`endif
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [COORD_W-1:0] rd_data,
    output logic [COORD_W-1:0] line_x0,
    output logic [COORD_W-1:0] line_y0,
    output logic [COORD_W-1:0] line_x1,
    output logic [COORD_W-1:0] line_y1,
    output logic               line_start,
    input  logic               line_done,
    output logic               busy,
    output logic               shape_done
);
    localparam int NW = 2*NUM_VERTS;
    localparam int BW = $clog2(NW);
    localparam int CW = $clog2(NW+1);
    localparam int KW = $clog2(NUM_VERTS+1);
    localparam int VW = $clog2(NUM_VERTS);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, WAIT_DONE} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [KW-1:0]                   k_q, k_d;
    logic [SHAPE_W-1:0]              shp_q, shp_d;
    logic                            closed_q, closed_d;
    logic [NW-1:0][COORD_W-1:0]      vbuf_q, vbuf_d;
    logic [ADDR_W-1:0]               rd_addr_q, rd_addr_d;
    logic [COORD_W-1:0]              x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic                            line_start_q, line_start_d;
    logic                            busy_q, busy_d;
    logic                            shape_done_q, shape_done_d;
    logic [KW-1:0]                   num_edges;
    logic [VW-1:0]                   v0, v1;
    logic [COORD_W-1:0]              off_x, off_y;

`ifdef SHAPE_OFFSET_EN
    logic [COORD_W-1:0] off_x_q, off_x_d, off_y_q, off_y_d;
    assign off_x = off_x_q;
    assign off_y = off_y_q;
`else
    assign off_x = '0;
    assign off_y = '0;
`endif

    function automatic logic [ADDR_W-1:0] base_addr(input logic [SHAPE_W-1:0] s);
        return ADDR_W'(s) * ADDR_W'(NW);
    endfunction

    assign num_edges = closed_q ? KW'(NUM_VERTS) : KW'(NUM_VERTS-1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        shp_d        = shp_q;
        closed_d     = closed_q;
        vbuf_d       = vbuf_q;
        rd_addr_d    = '0;
        x0_d         = x0_q;
        y0_d         = y0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        line_start_d = 1'b0;
        busy_d       = busy_q;
        shape_done_d = 1'b0;
`ifdef SHAPE_OFFSET_EN
        off_x_d      = off_x_q;
        off_y_d      = off_y_q;
`endif
        case (state_q)
            IDLE: begin
                // The shape_done cycle is already IDLE, but a start there must not be taken.
                if (start && !shape_done_q) begin
                    shp_d     = shape_sel;
                    closed_d  = closed;
`ifdef SHAPE_OFFSET_EN
                    off_x_d   = offset_x;
                    off_y_d   = offset_y;
`endif
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    rd_addr_d = base_addr(shape_sel);
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (cnt_q != '0) vbuf_d[BW'(cnt_q - CW'(1))] = rd_data;
                if (cnt_q == CW'(NW)) begin
                    k_d          = '0;
                    line_start_d = 1'b1;
                    state_d      = EMIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q + CW'(1) < CW'(NW))
                        rd_addr_d = base_addr(shp_q) + ADDR_W'(cnt_q) + ADDR_W'(1);
                end
            end
            EMIT: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (line_done) begin
                    if (KW'(k_q + KW'(1)) < num_edges) begin
                        k_d          = k_q + KW'(1);
                        line_start_d = 1'b1;
                        state_d      = EMIT;
                    end else begin
                        k_d          = '0;
                        shape_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Endpoints come from vbuf_d so the final RAM word captured this cycle is usable.
        v0 = VW'(k_d);
        v1 = (k_d == KW'(NUM_VERTS-1)) ? '0 : VW'(k_d + KW'(1));
        if (line_start_d) begin
            x0_d = vbuf_d[{v0, 1'b0}] + off_x;
            y0_d = vbuf_d[{v0, 1'b1}] + off_y;
            x1_d = vbuf_d[{v1, 1'b0}] + off_x;
            y1_d = vbuf_d[{v1, 1'b1}] + off_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            k_q          <= '0;
            shp_q        <= '0;
            closed_q     <= 1'b0;
            vbuf_q       <= '0;
            rd_addr_q    <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            line_start_q <= 1'b0;
            busy_q       <= 1'b0;
            shape_done_q <= 1'b0;
`ifdef SHAPE_OFFSET_EN
            off_x_q      <= '0;
            off_y_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            shp_q        <= shp_d;
            closed_q     <= closed_d;
            vbuf_q       <= vbuf_d;
            rd_addr_q    <= rd_addr_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            line_start_q <= line_start_d;
            busy_q       <= busy_d;
            shape_done_q <= shape_done_d;
`ifdef SHAPE_OFFSET_EN
            off_x_q      <= off_x_d;
            off_y_q      <= off_y_d;
`endif
        end
    end

    assign rd_addr    = rd_addr_q;
    assign line_x0    = x0_q;
    assign line_y0    = y0_q;
    assign line_x1    = x1_q;
    assign line_y1    = y1_q;
    assign line_start = line_start_q;
    assign busy       = busy_q;
    assign shape_done = shape_done_q;
endmodule

// File: tb/tb_shape_edge_sequencer.sv
// Directed bench for shape_edge_sequencer: closed/open draws, protocol noise, mid-fetch reset.
module tb_shape_edge_sequencer;
    localparam int CW = 10;
    localparam int NV = 4;
    localparam int SW = 3;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst, start, closed, line_done;
    logic [SW-1:0] shape_sel;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data;
    logic [CW-1:0] x0, y0, x1, y1;
    logic          line_start, busy, shape_done;
`ifdef SHAPE_OFFSET_EN
    logic [CW-1:0] offset_x, offset_y;
`endif

    logic [CW-1:0] ram [0:63];
    int n_vec = 0, n_err = 0, ls_cnt = 0, sd_cnt = 0;
    int ox = 0, oy = 0;

    shape_edge_sequencer #(.COORD_W(CW), .NUM_VERTS(NV), .SHAPE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .shape_sel(shape_sel), .closed(closed),
`ifdef SHAPE_OFFSET_EN
        .offset_x(offset_x), .offset_y(offset_y),
`endif
        .rd_addr(rd_addr), .rd_data(rd_data),
        .line_x0(x0), .line_y0(y0), .line_x1(x1), .line_y1(y1),
        .line_start(line_start), .line_done(line_done),
        .busy(busy), .shape_done(shape_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rd_data <= ram[rd_addr];
    always @(posedge clk) begin
        if (line_start) ls_cnt++;
        if (shape_done) sd_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] vtx(input int s, input int i);
        logic [CW-1:0] a, b;
        a = ram[s*8 + 2*i]     + ox[CW-1:0];
        b = ram[s*8 + 2*i + 1] + oy[CW-1:0];
        return {a, b};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic draw(input int s, input bit cl, input bit noisy);
        int c, ne, ls0, sd0;
        ne  = cl ? NV : NV-1;
        ls0 = ls_cnt;
        sd0 = sd_cnt;
        shape_sel = SW'(s); closed = cl; start = 1'b1;
        tick();
        start = 1'b0; shape_sel = '0; closed = 1'b0; c = 1;
        chk("busy_on", busy, 1);
        while (!line_start && c < 40) begin
            if (c <= 2*NV) chk("rd_addr_fetch", rd_addr, s*8 + c - 1);
            else           chk("rd_addr_idle", rd_addr, 0);
            line_done = noisy && (c == 3);
            tick();
            c++;
        end
        line_done = 1'b0;
        chk("first_latency", c, 10);
        for (int k = 0; k < ne; k++) begin
            chk("line_start", line_start, 1);
            chk("p0", {x0, y0}, vtx(s, k));
            chk("p1", {x1, y1}, vtx(s, (k+1) % NV));
            line_done = noisy;
            tick();
            line_done = 1'b0;
            if (noisy) begin start = 1'b1; shape_sel = 3'd1; end
            tick();
            tick();
            start = 1'b0; shape_sel = '0;
            chk("ls_low", line_start, 0);
            chk("hold", {x0, y0, x1, y1}, {vtx(s, k), vtx(s, (k+1) % NV)});
            line_done = 1'b1;
            tick();
            line_done = 1'b0;
        end
        chk("shape_done", shape_done, 1);
        chk("busy_off", busy, 0);
        if (noisy) start = 1'b1;
        tick();
        start = 1'b0;
        chk("sd_pulse", shape_done, 0);
        repeat (12) tick();
        chk("edge_count", ls_cnt - ls0, ne);
        chk("sd_count", sd_cnt - sd0, 1);
        chk("stay_idle", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = '0;
        ram[0] = 10;  ram[1] = 20;  ram[2] = 30;  ram[3] = 40;
        ram[4] = 50;  ram[5] = 60;  ram[6] = 80;  ram[7] = 333;
        ram[8] = 100; ram[9] = 7;   ram[10] = 200; ram[11] = 8;
        ram[12] = 300; ram[13] = 9; ram[14] = 400; ram[15] = 1023;
        rst = 1'b1; start = 1'b0; closed = 1'b0; line_done = 1'b0; shape_sel = '0;
`ifdef SHAPE_OFFSET_EN
        offset_x = '0; offset_y = '0;
`endif
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ls", line_start, 0);
        chk("rst_sd", shape_done, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_line", {x0, y0, x1, y1}, 0);
        rst = 1'b0;
        tick();

        draw(0, 1'b1, 1'b0);
        chk("closed_last_edge", {x0, y0, x1, y1}, {10'd80, 10'd333, 10'd10, 10'd20});
        draw(0, 1'b0, 1'b0);
        chk("open_last_edge", {x0, y0, x1, y1}, {10'd50, 10'd60, 10'd80, 10'd333});
        draw(0, 1'b1, 1'b1);
        draw(1, 1'b1, 1'b0);

        begin : rst_abort
            int sd0, ls0;
            shape_sel = '0; closed = 1'b1; start = 1'b1;
            tick();
            start = 1'b0;
            repeat (3) tick();
            rst = 1'b1;
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_addr", rd_addr, 0);
            chk("abort_ls", line_start, 0);
            chk("abort_sd", shape_done, 0);
            chk("abort_line", {x0, y0, x1, y1}, 0);
            sd0 = sd_cnt; ls0 = ls_cnt;
            tick();
            rst = 1'b0;
            repeat (20) tick();
            chk("abort_no_sd", sd_cnt - sd0, 0);
            chk("abort_no_ls", ls_cnt - ls0, 0);
        end
        draw(0, 1'b1, 1'b0);

`ifdef SHAPE_OFFSET_EN
        ox = 1000; oy = 5;
        offset_x = 10'd1000; offset_y = 10'd5;
        draw(0, 1'b1, 1'b0);
        ox = 0; oy = 0;
        offset_x = '0; offset_y = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
